// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. Holds the PC, issues in-order word
//             requests to instruction memory, buffers returned words in a
//             small FIFO and hands {instr, pc} to decode. Redirects flush the
//             FIFO and discard every response still in flight.
//  Ports    : clk, rst_n            - clock / async active-low reset
//             imem_req_*            - request channel (valid/ready/addr)
//             imem_rsp_*            - response channel (valid/data), in order
//             redirect_valid/_pc    - single-cycle restart request
//             instr_valid/_ready    - decode handshake
//             instr_data/_pc        - FIFO head word and its PC
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc
);

   localparam int            PW      = $clog2(FIFO_DEPTH);
   localparam int            CW      = PW + 1;
   localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] out_q, out_d;      // requests accepted, response not yet seen
   logic [CW-1:0] drop_q, drop_d;    // in-flight responses still to discard
   logic [CW-1:0] fcnt_q, fcnt_d;

   // PC tag queue: one entry per in-flight request, popped by every response
   logic [31:0]   tag_q [FIFO_DEPTH];
   logic [PW-1:0] tag_wr_q, tag_rd_q;

   // Instruction FIFO
   logic [31:0]   fdat_q [FIFO_DEPTH];
   logic [31:0]   fpc_q  [FIFO_DEPTH];
   logic [PW-1:0] fwr_q, frd_q;

   logic w_credit;
   logic w_req_fire;
   logic w_rsp_fire;
   logic w_rsp_keep;
   logic w_pop;
   logic w_unused;

   // Low address bits of a redirect target are forced to zero
   assign w_unused = ^redirect_pc[1:0];

   // Credit counts both in-flight requests and buffered words, so every
   // response is guaranteed a FIFO slot and imem_rsp needs no backpressure.
   assign w_credit       = ({1'b0, out_q} + {1'b0, fcnt_q}) < {1'b0, C_DEPTH};
   assign imem_req_valid = (state_q != ST_BOOT) && w_credit;
   assign imem_req_addr  = pc_q;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding (e.g. from before a reset) is ignored
   assign w_rsp_fire = imem_rsp_valid && (out_q != '0);
   // A response in the redirect cycle belongs to the old stream as well
   assign w_rsp_keep = w_rsp_fire && !redirect_valid && (drop_q == '0);

   assign instr_valid = (fcnt_q != '0);
   assign instr_data  = fdat_q[frd_q];
   assign instr_pc    = fpc_q[frd_q];
   assign w_pop       = instr_valid && instr_ready && !redirect_valid;

   always_comb begin
      out_d = out_q + {{(CW-1){1'b0}}, w_req_fire} - {{(CW-1){1'b0}}, w_rsp_fire};

      // On redirect everything still in flight after this cycle is stale,
      // which is exactly the next outstanding count.
      drop_d = drop_q;
      if (redirect_valid) begin
         drop_d = out_d;
      end else if (w_rsp_fire && (drop_q != '0)) begin
         drop_d = drop_q - 1'b1;
      end

      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = {redirect_pc[31:2], 2'b00};
      end else if (w_req_fire) begin
         pc_d = pc_q + 32'd4;
      end

      fcnt_d = fcnt_q;
      if (redirect_valid) begin
         fcnt_d = '0;
      end else begin
         fcnt_d = fcnt_q + {{(CW-1){1'b0}}, w_rsp_keep} - {{(CW-1){1'b0}}, w_pop};
      end

      state_d = state_q;
      case (state_q)
         ST_BOOT:  state_d = ST_RUN;
         ST_RUN:   if (redirect_valid && (drop_d != '0)) state_d = ST_FLUSH;
         ST_FLUSH: if (drop_d == '0) state_d = ST_RUN;
         default:  state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_BOOT;
         pc_q     <= RESET_PC;
         out_q    <= '0;
         drop_q   <= '0;
         fcnt_q   <= '0;
         tag_wr_q <= '0;
         tag_rd_q <= '0;
         fwr_q    <= '0;
         frd_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            tag_q[i]  <= '0;
            fdat_q[i] <= '0;
            fpc_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
         fcnt_q  <= fcnt_d;

         if (w_req_fire) begin
            tag_q[tag_wr_q] <= pc_q;
            tag_wr_q        <= tag_wr_q + 1'b1;
         end
         if (w_rsp_fire) begin
            tag_rd_q <= tag_rd_q + 1'b1;
         end

         if (redirect_valid) begin
            fwr_q <= '0;
            frd_q <= '0;
         end else begin
            if (w_rsp_keep) begin
               fdat_q[fwr_q] <= imem_rsp_data;
               fpc_q[fwr_q]  <= tag_q[tag_rd_q];
               fwr_q         <= fwr_q + 1'b1;
            end
            if (w_pop) begin
               frd_q <= frd_q + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit: directed phases push the
//             expected {pc, data} stream into a scoreboard queue; a monitor
//             pops and compares on each decode handshake. A behavioural
//             instruction memory answers requests in order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;

   fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
   exp_t exp_q[$];

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   mreq_t pend_q[$];

   int          mem_lat = 1;
   bit          inject_stray = 1'b0;
   int          cyc = 0;
   bit          acc_pend = 1'b0;
   logic [31:0] acc_addr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push_stream(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) begin
         logic [31:0] p;
         p = start + 32'(4 * i);
         exp_q.push_back('{pc: p, data: mem_word(p)});
      end
   endtask

   task automatic drain(input int budget, input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d instructions still undelivered after %0d cycles, required 0",
                  name, exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   task automatic redirect(input logic [31:0] tgt);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      tick();
      redirect_valid = 1'b0;
      check("flush_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("redirect_addr", imem_req_addr, {tgt[31:2], 2'b00});
   endtask

   task automatic restart(input logic [31:0] tgt);
      instr_ready = 1'b0;
      tick();
      redirect(tgt);
   endtask

   // Instruction memory: in-order responses, mem_lat cycles after acceptance
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (!rst_n) begin
            pend_q.delete();
            acc_pend       = 1'b0;
            imem_rsp_valid = 1'b0;
         end else begin
            if (acc_pend) pend_q.push_back('{addr: acc_addr, due: cyc + mem_lat - 1});
            if (inject_stray) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = 32'hBAD0_BAD0;
               inject_stray   = 1'b0;
            end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_word(pend_q[0].addr);
               void'(pend_q.pop_front());
            end else begin
               imem_rsp_valid = 1'b0;
            end
            acc_pend = imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
         end
      end
   end

   // Monitor: compare every consumed instruction against the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_instr: got pc=%h data=%h, required no instruction",
                        instr_pc, instr_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (instr_pc !== e.pc || instr_data !== e.data) begin
                  n_fail++;
                  $display("FAIL instr_stream: got pc=%h data=%h, required pc=%h data=%h",
                           instr_pc, instr_data, e.pc, e.data);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      bit found;
      rst_n          = 1'b0;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_req_valid",   {31'd0, imem_req_valid}, 32'd0);
      check("rst_req_addr",    imem_req_addr, RESET_PC);
      check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_instr_data",  instr_data, 32'd0);
      check("rst_instr_pc",    instr_pc, 32'd0);
      rst_n = 1'b1;
      check("boot_req_valid",  {31'd0, imem_req_valid}, 32'd0);
      tick();
      check("run_req_valid",   {31'd0, imem_req_valid}, 32'd1);
      check("run_req_addr",    imem_req_addr, RESET_PC);

      // Sequential stream from reset
      push_stream(RESET_PC, 8);
      instr_ready = 1'b1;
      drain(100, "t1_stream");
      instr_ready = 1'b0;

      // Decode stall: FIFO fills with two words, then requests stop
      restart(32'h0000_0000);
      repeat (10) tick();
      check("stall_req_valid",   {31'd0, imem_req_valid}, 32'd0);
      check("stall_instr_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_head_pc",     instr_pc, 32'h0000_0000);
      check("stall_head_data",   instr_data, mem_word(32'h0000_0000));
      push_stream(32'h0000_0000, 6);
      instr_ready = 1'b1;
      drain(100, "t2_release");
      instr_ready = 1'b0;

      // Memory backpressure: request address must hold
      imem_req_ready = 1'b0;
      restart(32'h0000_0008);
      for (int i = 0; i < 5; i++) begin
         check("hold_req_addr", imem_req_addr, 32'h0000_0008);
         tick();
      end
      check("hold_req_valid", {31'd0, imem_req_valid}, 32'd1);
      imem_req_ready = 1'b1;
      push_stream(32'h0000_0008, 4);
      instr_ready = 1'b1;
      drain(100, "t3_stream");
      instr_ready = 1'b0;

      // Redirect with slow memory: in-flight responses must be dropped
      restart(32'h0000_0008);
      mem_lat = 4;
      repeat (3) tick();
      redirect(32'h0000_0100);
      push_stream(32'h0000_0100, 3);
      instr_ready = 1'b1;
      drain(150, "t4_redirect");
      instr_ready = 1'b0;

      // Redirect coinciding with a response, then a second redirect
      restart(32'h0000_1000);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         tick();
         #2;
         if (imem_rsp_valid) found = 1'b1;
      end
      check("t5_rsp_seen", {31'd0, found}, 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0203;
      tick();
      check("t5_aligned_addr", imem_req_addr, 32'h0000_0200);
      check("t5_req_valid",    {31'd0, imem_req_valid}, 32'd1);
      redirect_pc = 32'h0000_0040;
      tick();
      redirect_valid = 1'b0;
      check("t5_flush_valid", {31'd0, instr_valid}, 32'd0);
      check("t5_second_addr", imem_req_addr, 32'h0000_0040);
      push_stream(32'h0000_0040, 4);
      instr_ready = 1'b1;
      drain(150, "t5_stream");
      instr_ready = 1'b0;

      // PC wrap at the top of the address space
      mem_lat = 1;
      restart(32'hFFFF_FFF8);
      push_stream(32'hFFFF_FFF8, 4);
      instr_ready = 1'b1;
      drain(100, "t6_wrap");
      instr_ready = 1'b0;

      // Reset mid-stream
      repeat (4) tick();
      check("t7_pre_valid", {31'd0, instr_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("t7_req_valid",   {31'd0, imem_req_valid}, 32'd0);
      check("t7_req_addr",    imem_req_addr, RESET_PC);
      check("t7_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("t7_instr_data",  instr_data, 32'd0);
      check("t7_instr_pc",    instr_pc, 32'd0);
      tick();
      tick();
      rst_n        = 1'b1;
      inject_stray = 1'b1;
      check("t7_boot_valid", {31'd0, imem_req_valid}, 32'd0);
      tick();
      check("t7_restart_valid", {31'd0, imem_req_valid}, 32'd1);
      check("t7_restart_addr",  imem_req_addr, RESET_PC);
      push_stream(RESET_PC, 4);
      instr_ready = 1'b1;
      drain(100, "t7_stream");
      instr_ready = 1'b0;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
